systolic_array_wrapper_spec: RTL and testbench

4×4 output-stationary systolic array for 8-bit unsigned matrix multiply C = A × B. It contains per-row A skew buffers, per-column B skew buffers, 16 multiply-accumulate PEs and a row-serial result unloader. The block sits under an external controller (FSM/SRAM driver) that sequences `load`, `shift` and `OutputSign`.

---
 rtl/systolic_array_wrapper_spec_if.sv | 32 +++
 rtl/systolic_array_wrapper_spec.sv | 145 ++++++++++++++
 tb/tb_systolic_array_wrapper_spec.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_wrapper_spec_if.sv
// Control/data bundle between the external sequencer and the 4x4 systolic array.
// The master side drives the strobes and skew-buffer writes; the slave side returns the result columns.
interface systolic_array_wrapper_spec_if #(
    parameter int DW = 8
);
    logic          load;
    logic          shift;
    logic          OutputSign;
    logic [2:0]    id_A_0, id_A_1, id_A_2, id_A_3;
    logic [2:0]    id_B_0, id_B_1, id_B_2, id_B_3;
    logic [DW-1:0] shift_in_A_0, shift_in_A_1, shift_in_A_2, shift_in_A_3;
    logic [DW-1:0] shift_in_B_0, shift_in_B_1, shift_in_B_2, shift_in_B_3;
    logic [DW-1:0] shift_out_0, shift_out_1, shift_out_2, shift_out_3;

    modport master (
        output load, shift, OutputSign,
        output id_A_0, id_A_1, id_A_2, id_A_3,
        output id_B_0, id_B_1, id_B_2, id_B_3,
        output shift_in_A_0, shift_in_A_1, shift_in_A_2, shift_in_A_3,
        output shift_in_B_0, shift_in_B_1, shift_in_B_2, shift_in_B_3,
        input  shift_out_0, shift_out_1, shift_out_2, shift_out_3
    );

    modport slave (
        input  load, shift, OutputSign,
        input  id_A_0, id_A_1, id_A_2, id_A_3,
        input  id_B_0, id_B_1, id_B_2, id_B_3,
        input  shift_in_A_0, shift_in_A_1, shift_in_A_2, shift_in_A_3,
        input  shift_in_B_0, shift_in_B_1, shift_in_B_2, shift_in_B_3,
        output shift_out_0, shift_out_1, shift_out_2, shift_out_3
    );
endinterface

// File: rtl/systolic_array_wrapper_spec.sv
// 4x4 output-stationary systolic array computing C = A x B on 8-bit unsigned operands.
// Define SA_SATURATE_EN to clamp unloaded results at 255 instead of wrapping modulo 256.
module systolic_array_wrapper_spec #(
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input logic                          clk,
    input logic                          rstn,
    systolic_array_wrapper_spec_if.slave bus
);
    logic [2:0]      id_a   [4];
    logic [2:0]      id_b   [4];
    logic [DW-1:0]   din_a  [4];
    logic [DW-1:0]   din_b  [4];
    logic [DW-1:0]   a_tail [4];
    logic [DW-1:0]   b_tail [4];
    logic [DW-1:0]   dout   [4];
    logic [DW-1:0]   a_out  [4][4];
    logic [DW-1:0]   b_out  [4][4];
    logic [ACCW-1:0] acc_w  [4][4];

    assign id_a[0] = bus.id_A_0;
    assign id_a[1] = bus.id_A_1;
    assign id_a[2] = bus.id_A_2;
    assign id_a[3] = bus.id_A_3;
    assign id_b[0] = bus.id_B_0;
    assign id_b[1] = bus.id_B_1;
    assign id_b[2] = bus.id_B_2;
    assign id_b[3] = bus.id_B_3;
    assign din_a[0] = bus.shift_in_A_0;
    assign din_a[1] = bus.shift_in_A_1;
    assign din_a[2] = bus.shift_in_A_2;
    assign din_a[3] = bus.shift_in_A_3;
    assign din_b[0] = bus.shift_in_B_0;
    assign din_b[1] = bus.shift_in_B_1;
    assign din_b[2] = bus.shift_in_B_2;
    assign din_b[3] = bus.shift_in_B_3;
    assign bus.shift_out_0 = dout[0];
    assign bus.shift_out_1 = dout[1];
    assign bus.shift_out_2 = dout[2];
    assign bus.shift_out_3 = dout[3];

    // Skew buffers: random-access write on load, shift toward position 6 on compute steps.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf
            logic [DW-1:0] buf_a_reg [7];
            logic [DW-1:0] buf_b_reg [7];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < 7; k++) begin
                        buf_a_reg[k] <= '0;
                        buf_b_reg[k] <= '0;
                    end
                end else if (bus.load) begin
                    // Index 7 matches no entry, so it is silently dropped.
                    for (int k = 0; k < 7; k++) begin
                        if (id_a[gi] == 3'(k)) buf_a_reg[k] <= din_a[gi];
                        if (id_b[gi] == 3'(k)) buf_b_reg[k] <= din_b[gi];
                    end
                end else if (bus.shift) begin
                    buf_a_reg[0] <= '0;
                    buf_b_reg[0] <= '0;
                    for (int k = 1; k < 7; k++) begin
                        buf_a_reg[k] <= buf_a_reg[k-1];
                        buf_b_reg[k] <= buf_b_reg[k-1];
                    end
                end
            end

            assign a_tail[gi] = buf_a_reg[6];
            assign b_tail[gi] = buf_b_reg[6];
        end
    endgenerate

    // PE grid: a flows right, b flows down, accumulators stay put until unloaded upward.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            for (gj = 0; gj < 4; gj++) begin : g_col
                logic [DW-1:0]   a_in;
                logic [DW-1:0]   b_in;
                logic [ACCW-1:0] acc_below;
                logic [2*DW-1:0] prod;
                logic [DW-1:0]   a_reg;
                logic [DW-1:0]   b_reg;
                logic [ACCW-1:0] acc_reg;

                if (gj == 0) begin : g_a_edge
                    assign a_in = a_tail[gi];
                end else begin : g_a_link
                    assign a_in = a_out[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_in = b_tail[gj];
                end else begin : g_b_link
                    assign b_in = b_out[gi-1][gj];
                end

                if (gi == 3) begin : g_acc_bottom
                    assign acc_below = '0;
                end else begin : g_acc_link
                    assign acc_below = acc_w[gi+1][gj];
                end

                assign prod = a_in * b_in;

                // A load cycle freezes the grid even if shift is also asserted.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        a_reg   <= '0;
                        b_reg   <= '0;
                        acc_reg <= '0;
                    end else if (!bus.load) begin
                        if (bus.shift) begin
                            a_reg   <= a_in;
                            b_reg   <= b_in;
                            acc_reg <= acc_reg + ACCW'(prod);
                        end else if (bus.OutputSign) begin
                            acc_reg <= acc_below;
                        end
                    end
                end

                assign a_out[gi][gj] = a_reg;
                assign b_out[gi][gj] = b_reg;
                assign acc_w[gi][gj] = acc_reg;
            end
        end
    endgenerate

    // Result formatting of the top accumulator row.
    generate
        for (gj = 0; gj < 4; gj++) begin : g_out
`ifdef SA_SATURATE_EN
            assign dout[gj] = !bus.OutputSign ? '0 :
                              (acc_w[0][gj] > ACCW'({DW{1'b1}})) ? {DW{1'b1}} :
                              acc_w[0][gj][DW-1:0];
`else
            assign dout[gj] = bus.OutputSign ? acc_w[0][gj][DW-1:0] : '0;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_systolic_array_wrapper_spec.sv
// Self-checking bench: directed and random matrix products compared against a plain matrix-multiply model.
module tb_systolic_array_wrapper_spec;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    int   ma [4][4];
    int   mb [4][4];
    int   mc [4][4];

    systolic_array_wrapper_spec_if #(.DW(8)) bus ();

    systolic_array_wrapper_spec #(.DW(8), .ACCW(18)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_out(input int c);
        case (c)
            0:       return bus.shift_out_0;
            1:       return bus.shift_out_1;
            2:       return bus.shift_out_2;
            default: return bus.shift_out_3;
        endcase
    endfunction

    function automatic logic [7:0] fmt(input int x);
`ifdef SA_SATURATE_EN
        return (x > 255) ? 8'd255 : 8'(x);
`else
        return 8'(x % 256);
`endif
    endfunction

    // Reference: PE(r,c) has accumulated every term k whose arrival edge k+r+c precedes nshift.
    task automatic compute_ref(input int nshift);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mc[r][c] = 0;
                for (int k = 0; k < 4; k++)
                    if (k + r + c < nshift) mc[r][c] += ma[r][k] * mb[k][c];
            end
    endtask

    task automatic drive_slot(input int s, input logic [2:0] ida, input logic [7:0] da,
                              input logic [2:0] idb, input logic [7:0] db);
        case (s)
            0: begin bus.id_A_0 = ida; bus.shift_in_A_0 = da; bus.id_B_0 = idb; bus.shift_in_B_0 = db; end
            1: begin bus.id_A_1 = ida; bus.shift_in_A_1 = da; bus.id_B_1 = idb; bus.shift_in_B_1 = db; end
            2: begin bus.id_A_2 = ida; bus.shift_in_A_2 = da; bus.id_B_2 = idb; bus.shift_in_B_2 = db; end
            default: begin bus.id_A_3 = ida; bus.shift_in_A_3 = da; bus.id_B_3 = idb; bus.shift_in_B_3 = db; end
        endcase
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.load = 1'b0;
        bus.shift = 1'b0;
        bus.OutputSign = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("reset_out%0d", c), get_out(c), 8'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.OutputSign = 1'b0;
    endtask

    task automatic load_mats();
        for (int i = 0; i < 4; i++) begin
            bus.load = 1'b1;
            for (int s = 0; s < 4; s++)
                drive_slot(s, 3'((3 - s) + i), 8'(ma[s][3 - i]), 3'((3 - s) + i), 8'(mb[3 - i][s]));
            @(posedge clk);
            #1;
        end
        bus.load = 1'b0;
    endtask

    // mode 0: back-to-back shifts; 1: one load+shift cycle with ignored index mid-run; 2: idle gaps.
    task automatic run_shifts(input int nshift, input int mode);
        for (int t = 0; t < nshift; t++) begin
            if (mode == 1 && t == 4) begin
                bus.load = 1'b1;
                bus.shift = 1'b1;
                for (int s = 0; s < 4; s++)
                    drive_slot(s, 3'd7, 8'($urandom_range(255)), 3'd7, 8'($urandom_range(255)));
                @(posedge clk);
                #1;
                bus.load = 1'b0;
            end
            bus.shift = 1'b1;
            @(posedge clk);
            #1;
            bus.shift = 1'b0;
            if (mode == 2) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic unload_check(input string name);
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("%s_idle_out%0d", name, c), get_out(c), 8'd0);
        bus.OutputSign = 1'b1;
        #1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++)
                check($sformatf("%s_r%0d_c%0d", name, r, c), get_out(c), (r < 4) ? fmt(mc[r][c]) : 8'd0);
            @(posedge clk);
            #1;
        end
        bus.OutputSign = 1'b0;
    endtask

    task automatic run_product(input string name, input int nshift, input int mode);
        do_reset();
        load_mats();
        run_shifts(nshift, mode);
        compute_ref(nshift);
        unload_check(name);
        $display("product %s shifts=%0d mode=%0d checks=%0d errors=%0d", name, nshift, mode, checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b1;
        bus.load = 1'b0;
        bus.shift = 1'b0;
        bus.OutputSign = 1'b0;
        for (int s = 0; s < 4; s++) drive_slot(s, 3'd0, 8'd0, 3'd0, 8'd0);
        #2;

        // Test 1: every result 30.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = j + 1;
                mb[i][j] = i + 1;
            end
        run_product("test1", 10, 0);

        // Test 2: border-ones A, with a load+shift pulse that must freeze the grid.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == 0 || i == 3 || j == 0 || j == 3) ? 1 : 0;
                mb[i][j] = 2 * (4 * i + j) + 12;
            end
        run_product("test2", 10, 1);

        // Test 3: diagonal/anti-diagonal B, idle cycles between shifts.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 3 * (4 * i + j);
                mb[i][j] = (i == j) ? 2 : ((i + j == 3) ? 1 : 0);
            end
        run_product("test3", 10, 2);

        // Overflow: all 255.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 255;
                mb[i][j] = 255;
            end
        run_product("overflow", 10, 0);

        // Abort a product mid-compute; the next product must carry no residue.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = $urandom_range(255);
                mb[i][j] = $urandom_range(255);
            end
        do_reset();
        load_mats();
        run_shifts(5, 0);

        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = $urandom_range(255);
                    mb[i][j] = (n == 0) ? $urandom_range(15) : $urandom_range(255);
                end
            case (n)
                0:       run_product("rand_small", 10, 0);
                1:       run_product("rand_partial", 6, 0);
                2:       run_product("rand_extra", 13, 0);
                3:       run_product("rand_pulse", 10, 1);
                default: run_product("rand_gaps", 10, 2);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
